// File: rtl/rob_mp_pkg.sv
// Shared types and widths for the reorder buffer: dispatch payload, per-entry state
// and the datapath widths used by the ROB and its consumers.
package rob_mp_pkg;

    localparam int REG_WIDTH     = 32;
    localparam int PC_WIDTH      = 32;
    localparam int ARF_ID_WIDTH  = 5;
    localparam int ROB_N_ENTRIES = 16;

    typedef struct packed {
        logic                    dst_valid;
        logic [ARF_ID_WIDTH-1:0] dst_arf_id;
        logic [PC_WIDTH-1:0]     pc;
    } rob_dispatch_data_t;

    typedef struct packed {
        logic                    valid;
        logic                    dst_valid;
        logic [ARF_ID_WIDTH-1:0] dst_arf_id;
        logic [PC_WIDTH-1:0]     pc;
        logic                    reg_ready;
        logic                    br_mp;
        logic                    ld_mp;
        logic [REG_WIDTH-1:0]    reg_data;
    } rob_entry_t;

endpackage

// File: rtl/rob_mp_ptr.sv
// Wrap-bit circular pointer for the ROB: ID_W index bits plus one wrap bit,
// with load taking priority over increment.
module rob_ptr #(
    parameter int ID_W = 4
) (
    input  logic          clk,
    input  logic          rst_aL,
    input  logic          i_inc,
    input  logic          i_load,
    input  logic [ID_W:0] i_load_val,
    output logic [ID_W:0] o_ptr
);

    logic [ID_W:0] r_ptr;

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            r_ptr <= '0;
        end else if (i_load) begin
            r_ptr <= i_load_val;
        end else if (i_inc) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/rob_mp.sv
// Reorder buffer: N writeback ports, M read ports, in-order single commit, mispredict flush.
// Optional macro ROB_WB_BYPASS_EN forwards same-cycle writebacks onto the read ports.
module rob_mp
    import rob_mp_pkg::*;
#(
    parameter int N_ENTRIES  = ROB_N_ENTRIES,
    parameter int N_WB_PORTS = 2,
    parameter int N_RD_PORTS = 2,
    localparam int ID_W      = $clog2(N_ENTRIES)
) (
    input  logic                                  clk,
    input  logic                                  rst_aL,
    output logic                                  dispatch_ready,
    input  logic                                  dispatch_valid,
    input  rob_dispatch_data_t                    dispatch_data,
    output logic [ID_W-1:0]                       dispatch_rob_id,
    input  logic [N_RD_PORTS-1:0][ID_W-1:0]       rd_rob_id,
    output logic [N_RD_PORTS-1:0]                 rd_ready,
    output logic [N_RD_PORTS-1:0][REG_WIDTH-1:0]  rd_data,
    input  logic [N_WB_PORTS-1:0]                 wb_valid,
    input  logic [N_WB_PORTS-1:0][ID_W-1:0]       wb_rob_id,
    input  logic [N_WB_PORTS-1:0][REG_WIDTH-1:0]  wb_data,
    input  logic [N_WB_PORTS-1:0]                 wb_br_mispredict,
    input  logic [N_WB_PORTS-1:0]                 wb_ld_mispredict,
    output logic                                  commit_valid,
    output logic                                  retire_valid,
    output logic [ARF_ID_WIDTH-1:0]               retire_arf_id,
    output logic [REG_WIDTH-1:0]                  retire_reg_data,
    output logic                                  flush_valid,
    output logic [PC_WIDTH-1:0]                   flush_pc
);

    logic [ID_W:0] w_head;
    logic [ID_W:0] w_tail;
    logic [ID_W:0] w_tail_load_val;
    rob_entry_t    r_entries      [N_ENTRIES];
    rob_entry_t    w_entries_next [N_ENTRIES];
    rob_entry_t    w_head_entry;
    logic          w_head_done;
    logic          w_ld_flush;
    logic          w_br_flush;
    logic          w_flush;
    logic          w_full;
    logic          w_dispatch;

    assign w_head_entry = r_entries[w_head[ID_W-1:0]];
    assign w_head_done  = w_head_entry.valid && w_head_entry.reg_ready;
    // A load mispredict replays the load itself, so it outranks a branch flag.
    assign w_ld_flush   = w_head_done && w_head_entry.ld_mp;
    assign w_br_flush   = w_head_done && w_head_entry.br_mp && !w_head_entry.ld_mp;
    assign w_flush      = w_ld_flush || w_br_flush;

    assign w_full = (w_head[ID_W-1:0] == w_tail[ID_W-1:0]) && (w_head[ID_W] != w_tail[ID_W]);
    assign dispatch_ready  = !w_full && !w_flush;
    assign w_dispatch      = dispatch_valid && dispatch_ready;
    assign dispatch_rob_id = w_tail[ID_W-1:0];

    assign commit_valid    = w_head_done && !w_head_entry.ld_mp;
    assign retire_valid    = commit_valid && w_head_entry.dst_valid;
    assign retire_arf_id   = commit_valid ? w_head_entry.dst_arf_id : '0;
    assign retire_reg_data = commit_valid ? w_head_entry.reg_data : '0;
    assign flush_valid     = w_flush;
    assign flush_pc        = w_flush ? w_head_entry.pc : '0;

    assign w_tail_load_val = w_ld_flush ? w_head : (w_head + 1'b1);

    rob_ptr #(.ID_W(ID_W)) u_head_ptr (
        .clk        (clk),
        .rst_aL     (rst_aL),
        .i_inc      (commit_valid),
        .i_load     (1'b0),
        .i_load_val ('0),
        .o_ptr      (w_head)
    );

    rob_ptr #(.ID_W(ID_W)) u_tail_ptr (
        .clk        (clk),
        .rst_aL     (rst_aL),
        .i_inc      (w_dispatch),
        .i_load     (w_flush),
        .i_load_val (w_tail_load_val),
        .o_ptr      (w_tail)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N_ENTRIES; gi++) begin : g_entry
            rob_entry_t w_next;

            always_comb begin
                w_next = r_entries[gi];
                if (w_flush) begin
                    w_next = '0;
                end else begin
                    if (w_dispatch && (w_tail[ID_W-1:0] == ID_W'(gi))) begin
                        w_next            = '0;
                        w_next.valid      = 1'b1;
                        w_next.dst_valid  = dispatch_data.dst_valid;
                        w_next.dst_arf_id = dispatch_data.dst_arf_id;
                        w_next.pc         = dispatch_data.pc;
                    end
                    // Ascending scan: the highest matching port's data lands last.
                    for (int k = 0; k < N_WB_PORTS; k++) begin
                        if (wb_valid[k] && (wb_rob_id[k] == ID_W'(gi)) && r_entries[gi].valid) begin
                            w_next.reg_ready = 1'b1;
                            w_next.reg_data  = wb_data[k];
                            w_next.br_mp     = w_next.br_mp | wb_br_mispredict[k];
                            w_next.ld_mp     = w_next.ld_mp | wb_ld_mispredict[k];
                        end
                    end
                    if (commit_valid && (w_head[ID_W-1:0] == ID_W'(gi))) begin
                        w_next = '0;
                    end
                end
            end

            assign w_entries_next[gi] = w_next;
        end

        for (gi = 0; gi < N_RD_PORTS; gi++) begin : g_rd
            rob_entry_t           w_rd_entry;
            logic                 w_ready;
            logic [REG_WIDTH-1:0] w_data;

            assign w_rd_entry = r_entries[rd_rob_id[gi]];

            always_comb begin
                w_ready = w_rd_entry.valid && w_rd_entry.reg_ready;
                w_data  = w_rd_entry.reg_data;
`ifdef ROB_WB_BYPASS_EN
                for (int k = 0; k < N_WB_PORTS; k++) begin
                    if (!w_flush && wb_valid[k] && (wb_rob_id[k] == rd_rob_id[gi]) && w_rd_entry.valid) begin
                        w_ready = 1'b1;
                        w_data  = wb_data[k];
                    end
                end
`endif
            end

            assign rd_ready[gi] = w_ready;
            assign rd_data[gi]  = w_data;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                r_entries[i] <= w_entries_next[i];
            end
        end
    end

endmodule
